// File: rtl/ascon_aead_sched.sv
//==============================================================================
// Module   : ascon_aead_sched
// Brief    : Round/phase scheduler for one Ascon-128a encryption job.
//            Optional cycle counter port enabled by ASCON_SCHED_CYCLE_CNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ascon_aead_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] ad_blks,
    input  logic [1:0] pt_blks,
    input  logic       blk_valid,
    output logic       blk_ready,
    output logic       busy,
    output logic       load_init,
    output logic       rnd_en,
    output logic [3:0] rnd_idx,
    output logic       key_xor_init,
    output logic       dsep_xor,
    output logic       key_xor_fin,
    output logic       key_xor_tag,
    output logic       absorb_ad,
    output logic       absorb_pt,
    output logic       c_valid,
    output logic       tag_valid
`ifdef ASCON_SCHED_CYCLE_CNT_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_INIT    = 4'd2,
        S_KEYX    = 4'd3,
        S_AD_WAIT = 4'd4,
        S_AD_PERM = 4'd5,
        S_DSEP    = 4'd6,
        S_PT_WAIT = 4'd7,
        S_PT_PERM = 4'd8,
        S_FKEY    = 4'd9,
        S_FIN     = 4'd10,
        S_TAG     = 4'd11
    } state_t;

    localparam logic [3:0] c_rnd_first_full = 4'd0;
    localparam logic [3:0] c_rnd_first_part = 4'd4;
    localparam logic [3:0] c_rnd_last       = 4'd11;

    state_t     r_state;
    logic [1:0] r_ad_rem;
    logic [1:0] r_pt_rem;
    logic [3:0] r_rnd_idx;
    logic       r_rnd_en;
    logic       r_busy;
    logic       r_ready_ad;
    logic       r_ready_pt;
    logic       r_load;
    logic       r_kinit;
    logic       r_dsep;
    logic       r_kfin;
    logic       r_tag;

    state_t     w_nxt_state;
    logic [1:0] w_nxt_ad;
    logic [1:0] w_nxt_pt;
    logic [3:0] w_nxt_idx;

    // Round index doubles as the loop counter; it is zero whenever no round runs.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ad    = r_ad_rem;
        w_nxt_pt    = r_pt_rem;
        w_nxt_idx   = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_state = S_LOAD;
                    w_nxt_ad    = ad_blks;
                    w_nxt_pt    = (pt_blks == 2'd0) ? 2'd1 : pt_blks;
                end
            end
            S_LOAD: begin
                w_nxt_state = S_INIT;
                w_nxt_idx   = c_rnd_first_full;
            end
            S_INIT: begin
                if (r_rnd_idx == c_rnd_last) w_nxt_state = S_KEYX;
                else                         w_nxt_idx   = r_rnd_idx + 4'd1;
            end
            S_KEYX: begin
                w_nxt_state = (r_ad_rem != 2'd0) ? S_AD_WAIT : S_DSEP;
            end
            S_AD_WAIT: begin
                if (blk_valid) begin
                    w_nxt_state = S_AD_PERM;
                    w_nxt_idx   = c_rnd_first_part;
                end
            end
            S_AD_PERM: begin
                if (r_rnd_idx == c_rnd_last) begin
                    w_nxt_ad    = r_ad_rem - 2'd1;
                    w_nxt_state = (r_ad_rem > 2'd1) ? S_AD_WAIT : S_DSEP;
                end else begin
                    w_nxt_idx = r_rnd_idx + 4'd1;
                end
            end
            S_DSEP: begin
                w_nxt_state = S_PT_WAIT;
            end
            S_PT_WAIT: begin
                // The final PT block skips its permutation and goes to finalisation.
                if (blk_valid) begin
                    if (r_pt_rem > 2'd1) begin
                        w_nxt_state = S_PT_PERM;
                        w_nxt_idx   = c_rnd_first_part;
                        w_nxt_pt    = r_pt_rem - 2'd1;
                    end else begin
                        w_nxt_state = S_FKEY;
                    end
                end
            end
            S_PT_PERM: begin
                if (r_rnd_idx == c_rnd_last) w_nxt_state = S_PT_WAIT;
                else                         w_nxt_idx   = r_rnd_idx + 4'd1;
            end
            S_FKEY: begin
                w_nxt_state = S_FIN;
                w_nxt_idx   = c_rnd_first_full;
            end
            S_FIN: begin
                if (r_rnd_idx == c_rnd_last) w_nxt_state = S_TAG;
                else                         w_nxt_idx   = r_rnd_idx + 4'd1;
            end
            S_TAG: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered by decoding the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ad_rem   <= 2'd0;
            r_pt_rem   <= 2'd0;
            r_rnd_idx  <= 4'd0;
            r_rnd_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_ready_ad <= 1'b0;
            r_ready_pt <= 1'b0;
            r_load     <= 1'b0;
            r_kinit    <= 1'b0;
            r_dsep     <= 1'b0;
            r_kfin     <= 1'b0;
            r_tag      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_ad_rem   <= w_nxt_ad;
            r_pt_rem   <= w_nxt_pt;
            r_rnd_idx  <= w_nxt_idx;
            r_rnd_en   <= (w_nxt_state == S_INIT)    || (w_nxt_state == S_FIN) ||
                          (w_nxt_state == S_AD_PERM) || (w_nxt_state == S_PT_PERM);
            r_busy     <= (w_nxt_state != S_IDLE);
            r_ready_ad <= (w_nxt_state == S_AD_WAIT);
            r_ready_pt <= (w_nxt_state == S_PT_WAIT);
            r_load     <= (w_nxt_state == S_LOAD);
            r_kinit    <= (w_nxt_state == S_KEYX);
            r_dsep     <= (w_nxt_state == S_DSEP);
            r_kfin     <= (w_nxt_state == S_FKEY);
            r_tag      <= (w_nxt_state == S_TAG);
        end
    end

    assign blk_ready    = r_ready_ad | r_ready_pt;
    assign busy         = r_busy;
    assign load_init    = r_load;
    assign rnd_en       = r_rnd_en;
    assign rnd_idx      = r_rnd_idx;
    assign key_xor_init = r_kinit;
    assign dsep_xor     = r_dsep;
    assign key_xor_fin  = r_kfin;
    assign key_xor_tag  = r_tag;
    assign tag_valid    = r_tag;
    assign absorb_ad    = r_ready_ad & blk_valid;
    assign absorb_pt    = r_ready_pt & blk_valid;
    assign c_valid      = r_ready_pt & blk_valid;

`ifdef ASCON_SCHED_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 16'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cycle_cnt <= 16'd0;
        end else if (r_busy && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

`default_nettype wire
